// File: rtl/led_frame_loader.sv
// Double-buffered 6x6 frame source for the LED matrix scan driver.
// Rows are written into a back buffer and published to img only at a frame boundary or on timeout.
module led_frame_loader #(
  parameter int SYNC_TIMEOUT  = 32768,
  parameter bit CLEAR_ON_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_row,
  input  logic [5:0]  wr_data,
  input  logic        commit,
  input  logic        frame_sync,
  output logic        pending,
  output logic        swapped,
  output logic        timeout_swap,
  output logic        err_row,
  input  logic        err_clr,
  output logic [35:0] img
);

  localparam int CW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((SYNC_TIMEOUT > 0) ? SYNC_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [35:0]   back;
  logic [35:0]   back_nxt;
  logic          accept;
  logic          row_ok;
  logic          tmo_hit;
  logic          swap;

  assign wr_ready = (state == IDLE);
  assign pending  = (state == PENDING);

  // Handshake decode, swap condition and next state
  always_comb begin
    state_nxt = state;
    accept    = wr_valid && (state == IDLE);
    row_ok    = (wr_row <= 3'd5);
    tmo_hit   = (SYNC_TIMEOUT != 0) && (cnt == TMO_LAST);
    swap      = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_nxt = PENDING;
        else        state_nxt = IDLE;
      end
      PENDING: begin
        swap = frame_sync || tmo_hit;
        if (swap) state_nxt = IDLE;
        else      state_nxt = PENDING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Back buffer update: row write, or optional clear right after a swap
  always_comb begin
    back_nxt = back;
    if (swap && CLEAR_ON_SWAP) begin
      back_nxt = 36'h0;
    end else if (accept && row_ok) begin
      for (int r = 0; r < 6; r++) begin
        if (wr_row == 3'(r)) back_nxt[6*r +: 6] = wr_data;
        else                 back_nxt[6*r +: 6] = back[6*r +: 6];
      end
    end else begin
      back_nxt = back;
    end
  end

  // State, timeout counter and buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      back  <= 36'h0;
      img   <= 36'h0;
    end else begin
      state <= state_nxt;
      back  <= back_nxt;
      if (swap) img <= back;
      if ((state == IDLE) && commit)                 cnt <= '0;
      else if ((state == PENDING) && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
    end
  end

  // Status flags; err_clr wins over a same-cycle bad-row write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swapped      <= 1'b0;
      timeout_swap <= 1'b0;
      err_row      <= 1'b0;
    end else begin
      swapped <= swap;
      if (swap) timeout_swap <= !frame_sync;
      if (err_clr)                  err_row <= 1'b0;
      else if (accept && !row_ok)   err_row <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Self-checking bench: directed scenarios plus random traffic against a row-array reference model.
module tb_led_frame_loader;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, commit, frame_sync, err_clr;
  logic [2:0]  wr_row;
  logic [5:0]  wr_data;
  logic        wr_ready, pending, swapped, timeout_swap, err_row;
  logic [35:0] img;
  logic        wr_ready_c, pending_c, swapped_c, timeout_swap_c, err_row_c;
  logic [35:0] img_c;

  int checks = 0;
  int errors = 0;

  // reference model: rows as arrays, [0] keeps back, [1] clears back on swap
  logic       m_pend, m_swapped, m_ts, m_err;
  int         m_wait;
  logic [5:0] m_back [2][6];
  logic [5:0] m_img  [2][6];

  always #5 clk = ~clk;

  led_frame_loader #(.SYNC_TIMEOUT(TMO), .CLEAR_ON_SWAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .frame_sync(frame_sync),
    .pending(pending), .swapped(swapped), .timeout_swap(timeout_swap),
    .err_row(err_row), .err_clr(err_clr), .img(img));

  led_frame_loader #(.SYNC_TIMEOUT(TMO), .CLEAR_ON_SWAP(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_c),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .frame_sync(frame_sync),
    .pending(pending_c), .swapped(swapped_c), .timeout_swap(timeout_swap_c),
    .err_row(err_row_c), .err_clr(err_clr), .img(img_c));

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] pack(input int k);
    logic [35:0] v;
    v = 36'h0;
    for (int r = 0; r < 6; r++) v[6*r +: 6] = m_img[k][r];
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_swapped = 1'b0; m_ts = 1'b0; m_err = 1'b0; m_wait = 0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 6; r++) begin
        m_back[k][r] = 6'h0;
        m_img[k][r]  = 6'h0;
      end
  endtask

  task automatic model_update();
    logic was_pend, acc, do_swap;
    if (!rst_n) begin
      model_reset();
    end else begin
      was_pend = m_pend;
      acc      = !was_pend && wr_valid;
      do_swap  = was_pend && (frame_sync || (m_wait == TMO - 1));
      m_swapped = do_swap;
      if (do_swap) begin
        for (int k = 0; k < 2; k++)
          for (int r = 0; r < 6; r++) begin
            m_img[k][r] = m_back[k][r];
            if (k == 1) m_back[k][r] = 6'h0;
          end
        m_ts   = !frame_sync;
        m_pend = 1'b0;
      end
      if (acc && wr_row < 3'd6)
        for (int k = 0; k < 2; k++) m_back[k][wr_row] = wr_data;
      if (err_clr) m_err = 1'b0;
      else if (acc && wr_row > 3'd5) m_err = 1'b1;
      if (!was_pend && commit) begin
        m_pend = 1'b1;
        m_wait = 0;
      end else if (was_pend && !do_swap) begin
        m_wait++;
      end
    end
  endtask

  task automatic compare_all();
    chk("img",      img,                 pack(0));
    chk("img_c",    img_c,               pack(1));
    chk("wr_ready", 36'(wr_ready),       36'(!m_pend));
    chk("pending",  36'(pending),        36'(m_pend));
    chk("swapped",  36'(swapped),        36'(m_swapped));
    chk("tmo_swap", 36'(timeout_swap),   36'(m_ts));
    chk("err_row",  36'(err_row),        36'(m_err));
    chk("pending_c", 36'(pending_c),     36'(m_pend));
    chk("swapped_c", 36'(swapped_c),     36'(m_swapped));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [2:0] row, input logic [5:0] data);
    wr_valid = 1'b1; wr_row = row; wr_data = data;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic sync_pulse();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_valid = 1'b0; wr_row = 3'd0; wr_data = 6'h0;
    commit = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    chk("rst_img", img, 36'h0);
    chk("rst_ready", 36'(wr_ready), 36'h1);
    chk("rst_pending", 36'(pending), 36'h0);
    chk("rst_err", 36'(err_row), 36'h0);

    // full frame, sync three cycles after commit
    wr(3'd0, 6'h3F); wr(3'd1, 6'h01); wr(3'd2, 6'h02);
    wr(3'd3, 6'h04); wr(3'd4, 6'h08); wr(3'd5, 6'h10);
    do_commit();
    step(); step(); step();
    chk("img_hold", img, 36'h0);
    sync_pulse();
    chk("frame1_img", img, 36'h4_0810_207F);
    chk("frame1_swapped", 36'(swapped), 36'h1);
    chk("frame1_tmo", 36'(timeout_swap), 36'h0);
    step();
    chk("swapped_once", 36'(swapped), 36'h0);

    // write held off while pending lands in the next frame only
    do_commit();
    wr_valid = 1'b1; wr_row = 3'd2; wr_data = 6'h3F;
    step();
    chk("pend_ready", 36'(wr_ready), 36'h0);
    sync_pulse();
    chk("pend_row2_old", 36'(img[17:12]), 36'h02);
    step();
    wr_valid = 1'b0;
    do_commit();
    sync_pulse();
    chk("pend_row2_new", 36'(img[17:12]), 36'h3F);

    // forced swap after exactly TMO pending cycles
    do_commit();
    n = 0;
    for (int i = 0; i < 20 && !swapped; i++) begin
      if (pending) n++;
      step();
    end
    chk("tmo_len", 36'(n), 36'(TMO));
    chk("tmo_flag", 36'(timeout_swap), 36'h1);

    // sync coincident with timeout: sync-driven, clears flag
    do_commit();
    for (int i = 0; i < TMO - 1; i++) step();
    sync_pulse();
    chk("coinc_swapped", 36'(swapped), 36'h1);
    chk("coinc_tmo", 36'(timeout_swap), 36'h0);

    // bad rows set err_row; err_clr wins on a same-cycle bad write
    wr(3'd6, 6'h2A);
    chk("err_set", 36'(err_row), 36'h1);
    err_clr = 1'b1;
    wr(3'd7, 6'h15);
    err_clr = 1'b0;
    chk("err_clr", 36'(err_row), 36'h0);

    // commit together with a row-0 write, then clear-on-swap instance shows zeros
    wr_valid = 1'b1; wr_row = 3'd0; wr_data = 6'h15;
    do_commit();
    wr_valid = 1'b0;
    sync_pulse();
    chk("commit_row0", 36'(img[5:0]), 36'h15);
    do_commit();
    sync_pulse();
    chk("clear_img", img_c, 36'h0);

    // reset in the middle of a pending commit
    do_commit();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_img", img, 36'h0);
    chk("midrst_pending", 36'(pending), 36'h0);
    step();
    rst_n = 1'b1;
    chk("midrst_ready", 36'(wr_ready), 36'h1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      wr_valid   = 1'($urandom_range(1, 0));
      wr_row     = 3'($urandom_range(7, 0));
      wr_data    = 6'($urandom_range(63, 0));
      commit     = ($urandom_range(3, 0) == 0);
      frame_sync = ($urandom_range(15, 0) == 0);
      err_clr    = ($urandom_range(15, 0) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
